// File: rtl/mxint_cast_pipe_if.sv
// Handshake and data bundle for the MxInt block caster: one input beat and one output beat.
interface mxint_cast_pipe_if #(
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 4
);
  logic signed [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE];
  logic        [IN_EXP_WIDTH-1:0]  edata_in;
  logic                            data_in_valid;
  logic                            data_in_ready;
  logic signed [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE];
  logic        [OUT_EXP_WIDTH-1:0] edata_out;
  logic                            sat_out;
  logic                            data_out_valid;
  logic                            data_out_ready;

  modport master (
    output mdata_in, edata_in, data_in_valid, data_out_ready,
    input  data_in_ready, mdata_out, edata_out, sat_out, data_out_valid
  );

  modport slave (
    input  mdata_in, edata_in, data_in_valid, data_out_ready,
    output data_in_ready, mdata_out, edata_out, sat_out, data_out_valid
  );
endinterface

// File: rtl/mxint_cast_pipe.sv
// Three-stage back-pressured MxInt block caster: normalises a shared-exponent block into a
// new mantissa/exponent format with floor or round-half-to-even and symmetric saturation.
module mxint_cast_pipe #(
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 4,
  parameter int ROUND_MODE    = 0
) (
  input logic clk,
  input logic rst,
  mxint_cast_pipe_if.slave bus
);
  localparam int IM  = IN_MAN_WIDTH;
  localparam int IE  = IN_EXP_WIDTH;
  localparam int OM  = OUT_MAN_WIDTH;
  localparam int OE  = OUT_EXP_WIDTH;
  localparam int LW  = $clog2(IM);
  localparam int EFW = ((IE > OE) ? IE : OE) + 8;
  localparam int WW  = IM + OM + 2;
  localparam int SW  = $clog2(WW);

  localparam logic signed [EFW-1:0] EBIAS_IN  = EFW'((64'd1 << (IE - 1)) - 64'd1);
  localparam logic signed [EFW-1:0] EBIAS_OUT = EFW'((64'd1 << (OE - 1)) - 64'd1);
  localparam logic signed [EFW-1:0] E_MAX     = EFW'((64'd1 << OE) - 64'd1);
  localparam logic signed [EFW-1:0] IN_OFF    = EFW'(IM - 2);
  localparam logic signed [EFW-1:0] OUT_OFF   = EFW'(OM - 2);
  localparam logic signed [EFW-1:0] SH_LCAP   = EFW'(OM);
  localparam logic signed [EFW-1:0] SH_RCAP   = EFW'(IM + 1);
  localparam logic signed [WW-1:0]  MAXV      = WW'((64'd1 << (OM - 1)) - 64'd1);
  localparam logic signed [WW-1:0]  MINV      = -MAXV;
  localparam logic [WW-1:0]         ONE_W     = WW'(1'b1);
  localparam logic                  RNE       = (ROUND_MODE == 1) ? 1'b1 : 1'b0;

  // Returns {lane_saturated, mantissa}. Left shifts are capped at OM (any nonzero lane already
  // overflows there); right shifts are capped at IM+1 where floor is 0/-1 and RNE is 0.
  function automatic logic [OM:0] cast_lane(input logic signed [IM-1:0] m,
                                             input logic signed [EFW-1:0] sh);
    logic signed [WW-1:0]  x, q, v;
    logic signed [EFW-1:0] neg;
    logic [WW-1:0]         mask;
    logic [SW-1:0]         amt;
    logic                  guard, sticky, up, sat;
    x      = WW'(m);
    neg    = -sh;
    q      = '0;
    mask   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    up     = 1'b0;
    if (!sh[EFW-1]) begin
      amt = (sh > SH_LCAP) ? SW'(OM) : sh[SW-1:0];
      v   = x <<< amt;
    end else begin
      amt    = (neg > SH_RCAP) ? SW'(IM + 1) : neg[SW-1:0];
      q      = x >>> amt;
      guard  = x[amt - SW'(1)];
      mask   = (ONE_W << (amt - SW'(1))) - ONE_W;
      sticky = |(x & mask);
      up     = RNE & guard & (sticky | q[0]);
      v      = q + $signed({{(WW-1){1'b0}}, up});
    end
    if (v > MAXV) begin
      sat = 1'b1;
      v   = MAXV;
    end else if (v < MINV) begin
      sat = 1'b1;
      v   = MINV;
    end else begin
      sat = 1'b0;
    end
    return {sat, v[OM-1:0]};
  endfunction

  logic                   v1_r, v2_r, v3_r;
  logic                   rdy1_s, rdy2_s, rdy3_s;
  logic signed [IM-1:0]   m1_r [BLOCK_SIZE];
  logic        [IE-1:0]   e1_r;
  logic        [LW-1:0]   l1_r;
  logic                   z1_r;
  logic signed [IM-1:0]   m2_r [BLOCK_SIZE];
  logic        [OE-1:0]   e2_r;
  logic signed [EFW-1:0]  shift2_r;
  logic                   expsat2_r, z2_r;
  logic signed [OM-1:0]   mo_r [BLOCK_SIZE];
  logic        [OE-1:0]   eo_r;
  logic                   sat_r;

  logic [IM-1:0]          mag_or_s;
  logic [LW-1:0]          lead_s;
  logic signed [EFW-1:0]  e_full_s, e_clamp_s, shift_s;
  logic [OM:0]            lane_s [BLOCK_SIZE];
  logic                   lane_sat_s;

  assign rdy3_s             = ~v3_r | bus.data_out_ready;
  assign rdy2_s             = ~v2_r | rdy3_s;
  assign rdy1_s             = ~v1_r | rdy2_s;
  assign bus.data_in_ready  = rdy1_s;
  assign bus.data_out_valid = v3_r;
  assign bus.mdata_out      = mo_r;
  assign bus.edata_out      = eo_r;
  assign bus.sat_out        = sat_r;

  // Leading-one position of the OR of lane magnitudes (the most negative value counts as 2^(IM-1)).
  always_comb begin
    mag_or_s = '0;
    lead_s   = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      mag_or_s = mag_or_s | (bus.mdata_in[i][IM-1] ? $unsigned(-bus.mdata_in[i])
                                                   : $unsigned(bus.mdata_in[i]));
    end
    for (int b = 0; b < IM; b++) begin
      lead_s = mag_or_s[b] ? LW'(b) : lead_s;
    end
  end

  // Rebias the exponent, clamp it, and fold any clamp residue into the mantissa shift.
  always_comb begin
    e_full_s = $signed({{(EFW-IE){1'b0}}, e1_r}) - EBIAS_IN + EBIAS_OUT
             + $signed({{(EFW-LW){1'b0}}, l1_r}) - IN_OFF;
    if (e_full_s[EFW-1]) begin
      e_clamp_s = '0;
    end else if (e_full_s > E_MAX) begin
      e_clamp_s = E_MAX;
    end else begin
      e_clamp_s = e_full_s;
    end
    shift_s = OUT_OFF - $signed({{(EFW-LW){1'b0}}, l1_r}) + (e_full_s - e_clamp_s);
  end

  // Per-lane shift, round and saturate.
  always_comb begin
    lane_sat_s = 1'b0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      lane_s[i]  = cast_lane(m2_r[i], shift2_r);
      lane_sat_s = lane_sat_s | lane_s[i][OM];
    end
  end

  // S1: capture the input block with its leading-one index and all-zero flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r <= 1'b0;
      e1_r <= '0;
      l1_r <= '0;
      z1_r <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) m1_r[i] <= '0;
    end else if (rdy1_s) begin
      v1_r <= bus.data_in_valid;
      if (bus.data_in_valid) begin
        m1_r <= bus.mdata_in;
        e1_r <= bus.edata_in;
        l1_r <= lead_s;
        z1_r <= (mag_or_s == '0);
      end
    end
  end

  // S2: hold mantissas alongside the clamped exponent, shift and exponent-saturation flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r      <= 1'b0;
      e2_r      <= '0;
      shift2_r  <= '0;
      expsat2_r <= 1'b0;
      z2_r      <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) m2_r[i] <= '0;
    end else if (rdy2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        m2_r      <= m1_r;
        e2_r      <= e_clamp_s[OE-1:0];
        shift2_r  <= shift_s;
        expsat2_r <= (e_full_s > E_MAX);
        z2_r      <= z1_r;
      end
    end
  end

  // S3: output register; an all-zero block forces a clean zero beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3_r  <= 1'b0;
      eo_r  <= '0;
      sat_r <= 1'b0;
      for (int i = 0; i < BLOCK_SIZE; i++) mo_r[i] <= '0;
    end else if (rdy3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          mo_r[i] <= z2_r ? '0 : $signed(lane_s[i][OM-1:0]);
        end
        eo_r  <= z2_r ? '0 : e2_r;
        sat_r <= ~z2_r & (expsat2_r | lane_sat_s);
      end
    end
  end
endmodule

// File: tb/tb_mxint_cast_pipe.sv
// Bench for mxint_cast_pipe: floor and RNE instances share stimulus; a value-level model
// feeds per-instance scoreboards, and directed vectors carry hand-computed results.
module tb_mxint_cast_pipe;
  typedef struct { int m0; int m1; int e; bit sat; } exp_t;

  logic              clk;
  logic              rst;
  logic signed [7:0] in_m [2];
  logic        [7:0] in_e;
  logic              in_valid;
  logic              out_ready;

  int checks   = 0;
  int failures = 0;
  int pushes   = 0;
  int pops     = 0;
  exp_t q0[$];
  exp_t q1[$];

  mxint_cast_pipe_if #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4),
                       .OUT_EXP_WIDTH(4), .BLOCK_SIZE(2)) if0 ();
  mxint_cast_pipe_if #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4),
                       .OUT_EXP_WIDTH(4), .BLOCK_SIZE(2)) if1 ();

  assign if0.mdata_in       = in_m;
  assign if0.edata_in       = in_e;
  assign if0.data_in_valid  = in_valid;
  assign if0.data_out_ready = out_ready;
  assign if1.mdata_in       = in_m;
  assign if1.edata_in       = in_e;
  assign if1.data_in_valid  = in_valid;
  assign if1.data_out_ready = out_ready;

  mxint_cast_pipe #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4), .OUT_EXP_WIDTH(4),
                    .BLOCK_SIZE(2), .ROUND_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mxint_cast_pipe #(.IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4), .OUT_EXP_WIDTH(4),
                    .BLOCK_SIZE(2), .ROUND_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int m0, input int m1, input int e, input bit s);
    exp_t r;
    r.m0 = m0; r.m1 = m1; r.e = e; r.sat = s;
    return r;
  endfunction

  // Value-level reference: v = m * 2^(e - bias - 6) re-expressed with 4-bit mantissa, 4-bit exponent.
  function automatic exp_t model(input int m0, input int m1, input int e, input bit rne);
    exp_t r;
    int m [2];
    int v [2];
    int mag, l, ef, eo, sh, rr;
    longint den, q, rem;
    bit s;
    m[0] = m0; m[1] = m1;
    r = mk(0, 0, 0, 1'b0);
    mag = 0;
    for (int i = 0; i < 2; i++) mag = mag | ((m[i] < 0) ? -m[i] : m[i]);
    if (mag == 0) return r;
    l = 0;
    for (int b = 0; b < 8; b++) if (((mag >> b) & 1) == 1) l = b;
    ef = e - 127 + 7 + l - 6;
    eo = (ef < 0) ? 0 : ((ef > 15) ? 15 : ef);
    s  = (ef > 15);
    sh = 2 - l + (ef - eo);
    for (int i = 0; i < 2; i++) begin
      if (sh >= 0) begin
        q = longint'(m[i]) * (longint'(1) << ((sh > 17) ? 17 : sh));
      end else begin
        rr = -sh;
        if (rr > 40) begin
          q = (m[i] < 0 && !rne) ? -1 : 0;
        end else begin
          den = longint'(1) << rr;
          q = longint'(m[i]) / den;
          if ((longint'(m[i]) % den) != 0 && m[i] < 0) q = q - 1;
          rem = longint'(m[i]) - q * den;
          if (rne && ((2 * rem > den) || ((2 * rem == den) && (q % 2 != 0)))) q = q + 1;
        end
      end
      if (q > 7) begin q = 7; s = 1'b1; end
      else if (q < -7) begin q = -7; s = 1'b1; end
      v[i] = int'(q);
    end
    return mk(v[0], v[1], eo, s);
  endfunction

  task automatic check_beat(input string name, input int gm0, input int gm1, input int ge,
                            input bit gs, input exp_t w);
    checks++;
    if (gm0 != w.m0 || gm1 != w.m1 || ge != w.e || gs != w.sat) begin
      failures++;
      $display("FAIL %s: got m={%0d,%0d} e=%0d sat=%0d, want m={%0d,%0d} e=%0d sat=%0d",
               name, gm0, gm1, ge, gs, w.m0, w.m1, w.e, w.sat);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Scoreboard: push model results on input handshakes, check each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (in_valid && if0.data_in_ready) begin
        q0.push_back(model(int'(in_m[0]), int'(in_m[1]), int'(in_e), 1'b0));
        pushes++;
      end
      if (in_valid && if1.data_in_ready)
        q1.push_back(model(int'(in_m[0]), int'(in_m[1]), int'(in_e), 1'b1));
      if (if0.data_out_valid && if0.data_out_ready) begin
        pops++;
        if (q0.size() == 0) check_int("floor_unexpected_beat", 1, 0);
        else check_beat("floor_stream", int'(if0.mdata_out[0]), int'(if0.mdata_out[1]),
                        int'(if0.edata_out), if0.sat_out, q0.pop_front());
      end
      if (if1.data_out_valid && if1.data_out_ready) begin
        if (q1.size() == 0) check_int("rne_unexpected_beat", 1, 0);
        else check_beat("rne_stream", int'(if1.mdata_out[0]), int'(if1.mdata_out[1]),
                        int'(if1.edata_out), if1.sat_out, q1.pop_front());
      end
    end
  end

  // One beat into an empty pipe: check 3-edge latency and literal results for both modes.
  task automatic run_vec(input string name, input int m0, input int m1, input int e,
                         input exp_t w0, input exp_t w1);
    int n;
    @(posedge clk); #1;
    in_m[0] = 8'(m0); in_m[1] = 8'(m1); in_e = 8'(e); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!if0.data_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_int({name, "_latency"}, n, 3);
    check_beat({name, "_floor"}, int'(if0.mdata_out[0]), int'(if0.mdata_out[1]),
               int'(if0.edata_out), if0.sat_out, w0);
    check_beat({name, "_rne"}, int'(if1.mdata_out[0]), int'(if1.mdata_out[1]),
               int'(if1.edata_out), if1.sat_out, w1);
  endtask

  task automatic stream(input int nbeats, input bit toggle);
    int idx;
    int cyc;
    bit acc;
    idx = 0;
    cyc = 0;
    @(posedge clk); #1;
    in_m[0] = 8'($urandom_range(0, 255)); in_m[1] = 8'($urandom_range(0, 255));
    in_e = 8'($urandom_range(100, 150)); in_valid = 1'b1;
    while (idx < nbeats && cyc < 400) begin
      @(negedge clk);
      acc = if0.data_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (toggle) out_ready = ~out_ready;
      if (acc) begin
        idx++;
        in_m[0] = 8'($urandom_range(0, 255)); in_m[1] = 8'($urandom_range(0, 255));
        in_e = 8'($urandom_range(100, 150));
        if (idx >= nbeats) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_int("stream_accepted", idx, nbeats);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_m[0] = 8'sd0; in_m[1] = 8'sd0; in_e = 8'd0;
    #1 rst = 1'b0;
    #10;
    check_beat("reset_floor", int'(if0.mdata_out[0]), int'(if0.mdata_out[1]),
               int'(if0.edata_out), if0.sat_out, mk(0, 0, 0, 1'b0));
    check_int("reset_out_valid", int'(if0.data_out_valid) + int'(if1.data_out_valid), 0);
    check_int("reset_in_ready", int'(if0.data_in_ready), 1);
    @(posedge clk); #1 rst = 1'b1;

    check_beat("pin_model_t2_rne", 0, 0, 0, 1'b0, mk(0, 0, 0, 1'b0));
    begin
      exp_t p;
      p = model(120, 24, 127, 1'b1);
      check_beat("pin_model_t2_rne", p.m0, p.m1, p.e, p.sat, mk(7, 2, 7, 1'b1));
      p = model(64, -32, 0, 1'b0);
      check_beat("pin_model_t4_floor", p.m0, p.m1, p.e, p.sat, mk(0, -1, 0, 1'b0));
      p = model(-128, 0, 127, 1'b1);
      check_beat("pin_model_t5_min", p.m0, p.m1, p.e, p.sat, mk(-4, 0, 8, 1'b0));
    end

    run_vec("t1_basic",   64,  -32, 127, mk(4, -2, 7, 1'b0),  mk(4, -2, 7, 1'b0));
    run_vec("t2_round",  120,   24, 127, mk(7, 1, 7, 1'b0),   mk(7, 2, 7, 1'b1));
    run_vec("t3_exp_hi",  64,  -32, 250, mk(7, -7, 15, 1'b1), mk(7, -7, 15, 1'b1));
    run_vec("t4_exp_lo",  64,  -32,   0, mk(0, -1, 0, 1'b0),  mk(0, 0, 0, 1'b0));
    run_vec("t5_zero",     0,    0, 200, mk(0, 0, 0, 1'b0),   mk(0, 0, 0, 1'b0));
    run_vec("t5_min",   -128,    0, 127, mk(-4, 0, 8, 1'b0),  mk(-4, 0, 8, 1'b0));

    stream(8, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    cyc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_int("stream_drained", q0.size() + q1.size(), 0);
    check_int("stream_beats_out", pops, pushes);

    out_ready = 1'b0;
    stream(3, 1'b0);
    check_int("stall_out_valid", int'(if0.data_out_valid), 1);
    check_int("stall_in_ready", int'(if0.data_in_ready), 0);
    #1 rst = 1'b0;
    #1;
    check_int("rst_valid_drop", int'(if0.data_out_valid) + int'(if1.data_out_valid), 0);
    check_int("rst_in_ready", int'(if0.data_in_ready) + int'(if1.data_in_ready), 2);
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (if0.data_out_valid || if1.data_out_valid) stale++;
    end
    check_int("post_rst_stale", stale, 0);
    check_int("post_rst_in_ready", int'(if0.data_in_ready), 1);
    run_vec("post_rst", 64, -32, 127, mk(4, -2, 7, 1'b0), mk(4, -2, 7, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mxint_cast_pipe.md
Name: mxint_cast_pipe

Overview:
Pipelined, fully back-pressured MxInt block caster. It takes one block of BLOCK_SIZE signed mantissas with a shared biased exponent and converts it to a normalised output format. Mantissa and exponent widths are parametrised independently, and the rounding mode is selectable. A per-beat saturation flag is produced alongside the data. It sits between MxInt layers where the input may be un-normalised; it sustains one block per cycle with fixed 3-cycle latency.

Parameters:
IN_MAN_WIDTH, 8, input mantissa width, signed two's complement, 4..32
IN_EXP_WIDTH, 8, input exponent width, unsigned biased, >2
OUT_MAN_WIDTH, 8, output mantissa width, signed, 4..32
OUT_EXP_WIDTH, 8, output exponent width, unsigned biased, >2
BLOCK_SIZE, 4, lanes per block, >=1
ROUND_MODE, 0, 0 = floor (arithmetic shift), 1 = round-half-to-even

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
mdata_in  in  IN_MAN_WIDTH x [BLOCK_SIZE]  input mantissas (unpacked array)
edata_in  in  IN_EXP_WIDTH  input shared exponent
data_in_valid  in  1  input beat valid
data_in_ready  out  1  input beat accepted when valid&ready
mdata_out  out  OUT_MAN_WIDTH x [BLOCK_SIZE]  output mantissas
edata_out  out  OUT_EXP_WIDTH  output shared exponent
sat_out  out  1  any lane saturated or exponent clamped high in this beat
data_out_valid  out  1  output beat valid
data_out_ready  in  1  downstream ready

Behaviour:
- Biases: EBIAS_IN = 2^(IN_EXP_WIDTH-1)-1, EBIAS_OUT = 2^(OUT_EXP_WIDTH-1)-1.
- Value semantics: v = m * 2^(e - EBIAS - (MAN_WIDTH-2)).
- Reset (rst=0, async): all stage valids, data_out_valid, sat_out, mdata_out and edata_out go to 0. data_in_ready = 1 after reset.
- A beat in flight when reset asserts is discarded. No partial output appears after reset releases.
- Pipeline has 3 stages (S1, S2, S3 = output register), each with a valid bit.
- Each stage loads when its valid is 0 or the next stage accepts.
- Combinational ready chain: data_in_ready = !v1 | (ready into S2).
- Latency is 3 cycles from input accept to data_out_valid with no stall. Throughput is 1 beat/cycle.
- Output holds stable while data_out_valid & !data_out_ready. No beat is dropped or duplicated.
- S1: register mantissas and exponent. Compute L = MSB index of the OR of |m_i| over lanes (|-2^(IN-1)| = 2^(IN-1), so L = IN_MAN_WIDTH-1). Set zero flag Z if all lanes are 0.
- S2: E_full = e - EBIAS_IN + EBIAS_OUT + L - (IN_MAN_WIDTH-2), signed, wide enough for no overflow.
  - E_out = clamp(E_full, 0, 2^OUT_EXP_WIDTH-1).
  - shift = (OUT_MAN_WIDTH-2) - L + (E_full - E_out), signed.
  - Set expsat = (E_full > max).
- S3, per lane:
  - m = 0 gives 0.
  - shift >= 0: result = m << shift, saturated.
  - shift < 0: right shift by -shift. Floor uses arithmetic shift. RNE rounds on the guard/sticky bits, with ties to even.
  - Shift magnitudes >= IN_MAN_WIDTH+1 are handled without wrap: floor gives 0 or -1, RNE gives 0.
  - Saturate to the symmetric range ±(2^(OUT_MAN_WIDTH-1)-1). This includes rounding carry-out. The exponent is not re-adjusted.
- Z = 1 forces edata_out = 0, all mantissas 0 and sat_out = 0.
- sat_out = expsat | OR of lane saturations.

Test Plan:
All scenarios use IN_MAN=8, IN_EXP=8, OUT_MAN=4, OUT_EXP=4, BLOCK_SIZE=2, so EBIAS_IN=127 and EBIAS_OUT=7.
1. m={64,-32}, e=127 -> L=6, shift=-4; out {4,-2}, e=7, sat=0, valid exactly 3 cycles after accept.
2. m={120,24}, e=127 -> ROUND_MODE=0: {7,1}, sat=0. ROUND_MODE=1: {7,2} with 7.5 rounding to 8 and saturating to 7, sat=1.
3. m={64,-32}, e=250 -> E_full=130 clamps to e=15; out {7,-7}, sat=1.
4. m={64,-32}, e=0 -> e=0; floor gives {0,-1}, RNE gives {0,0}, sat=0.
5. m={0,0}, e=200 -> out {0,0}, e=0, sat=0. Also m={-128,0}, e=127 -> L=7; shift=-5 gives -4, e=8, sat=0.
6. Stream 8 random beats with data_out_ready toggling every cycle -> output order and values match the model, no loss or duplication. Assert rst mid-stream -> valids drop immediately, data_in_ready=1 after release, no stale output appears.
